// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one of four requesters access to a shared external ALU.
// The winner's op/operands are registered onto alu_op/alu_a/alu_b, held for
// ALU_LAT cycles, then alu_result is captured and offered on rsp_* with a
// valid/ready handshake. Only one transaction is in flight at a time.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin arbitration (search starts after the last grant)
//   undefined -> fixed priority (lowest requesting index wins)
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [11:0]  op_in,
    input  logic [127:0] a_in,
    input  logic [127:0] b_in,
    output logic [2:0]   alu_op,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    input  logic [31:0]  alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [1:0]   rsp_id,
    output logic [31:0]  rsp_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Value loaded into the ISSUE down-counter on a grant.
    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

`ifdef ALU_ARB_RR_EN
    // Round-robin pick: first set request at ptr+1, ptr+2, ... wrapping mod 4.
    function automatic logic [1:0] f_pick_rr(input logic [3:0] req_v,
                                             input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 1; k < 5; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_v[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction
`else
    // Fixed-priority pick: lowest set request index wins.
    function automatic logic [1:0] f_pick_fixed(input logic [3:0] req_v);
        logic [1:0] win;
        win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_v[k]) begin
                win = 2'(k);
            end else begin
                win = win;
            end
        end
        return win;
    endfunction
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_grant;
    logic        w_capture;
    logic        w_accept;
    logic [1:0]  w_win;
    logic [2:0]  w_sel_op;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;

    logic [1:0]  r_gnt_id;
    logic [2:0]  r_alu_op;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic        r_rsp_valid;
    logic [1:0]  r_rsp_id;
    logic [31:0] r_rsp_data;
    logic        r_busy;

`ifdef ALU_ARB_RR_EN
    logic [1:0]  r_rr_ptr;

    // Round-robin pointer remembers the most recent grant; 3 makes index 0 first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 2'd3;
        end else if (w_grant) begin
            r_rr_ptr <= w_win;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign w_win = f_pick_rr(req, r_rr_ptr);
`else
    assign w_win = f_pick_fixed(req);
`endif

    // Route the winning requester's op and operands.
    always_comb begin
        w_sel_op = op_in[2:0];
        w_sel_a  = a_in[31:0];
        w_sel_b  = b_in[31:0];
        case (w_win)
            2'd1: begin
                w_sel_op = op_in[5:3];
                w_sel_a  = a_in[63:32];
                w_sel_b  = b_in[63:32];
            end
            2'd2: begin
                w_sel_op = op_in[8:6];
                w_sel_a  = a_in[95:64];
                w_sel_b  = b_in[95:64];
            end
            2'd3: begin
                w_sel_op = op_in[11:9];
                w_sel_a  = a_in[127:96];
                w_sel_b  = b_in[127:96];
            end
            default: begin
                w_sel_op = op_in[2:0];
                w_sel_a  = a_in[31:0];
                w_sel_b  = b_in[31:0];
            end
        endcase
    end

    // Next-state, counter and control strobes for the IDLE/ISSUE/RESP sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req != 4'd0) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = LAT_LOAD;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The cycle with one count left is the last ISSUE cycle: capture now.
                if (r_cnt <= 3'd1) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_cnt_nxt   = 3'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, down-counter and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // ALU drive registers load only on a grant, so they hold through ISSUE, RESP and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op <= 3'd0;
            r_alu_a  <= 32'd0;
            r_alu_b  <= 32'd0;
            r_gnt_id <= 2'd0;
        end else if (w_grant) begin
            r_alu_op <= w_sel_op;
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
            r_gnt_id <= w_win;
        end else begin
            r_alu_op <= r_alu_op;
            r_alu_a  <= r_alu_a;
            r_alu_b  <= r_alu_b;
            r_gnt_id <= r_gnt_id;
        end
    end

    // Response registers: result sampled once at capture, later alu_result changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 2'd0;
            r_rsp_data  <= 32'd0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_gnt_id;
            r_rsp_data  <= alu_result;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= r_rsp_id;
            r_rsp_data  <= r_rsp_data;
        end else begin
            r_rsp_valid <= r_rsp_valid;
            r_rsp_id    <= r_rsp_id;
            r_rsp_data  <= r_rsp_data;
        end
    end

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. Two instances (ALU_LAT=1 and ALU_LAT=3)
// share the same request stimulus; each is compared every cycle against a
// transaction-level reference model. Build with or without ALU_ARB_RR_EN.
module tb_alu_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_s;
    logic [11:0]  op_in_s;
    logic [127:0] a_in_s;
    logic [127:0] b_in_s;
    logic         rsp_ready_s;
    logic [31:0]  noise_s;
    bit           noise_en;
    bit           log_en;

    logic [2:0]   alu_op_s     [2];
    logic [31:0]  alu_a_s      [2];
    logic [31:0]  alu_b_s      [2];
    logic [31:0]  alu_result_s [2];
    logic         rsp_valid_s  [2];
    logic [1:0]   rsp_id_s     [2];
    logic [31:0]  rsp_data_s   [2];
    logic         busy_s       [2];

    int n_checks;
    int n_errors;

    // Reference model state, one slot per instance.
    bit          m_busy  [2];
    bit          m_valid [2];
    int          m_edges [2];
    int          m_id    [2];
    int          m_last  [2];
    int          m_id_out[2];
    logic [2:0]  e_op    [2];
    logic [31:0] e_a     [2];
    logic [31:0] e_b     [2];
    logic [31:0] m_data  [2];

    int obs_id  [2];
    int obs_data[2];
    int gnt_log0[$];
    int gnt_log1[$];
    int exp_gnt [5];

    // Behavioural model of the external ALU.
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return ~a;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Arbitration rule: scan requester indices in priority order, first set one wins.
    function automatic int model_pick(input logic [3:0] r, input int last);
        int start;
`ifdef ALU_ARB_RR_EN
        start = (last + 1) % 4;
`else
        start = (last < 0) ? 0 : 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return 0;
    endfunction

    alu_arbiter #(.ALU_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req(req_s), .op_in(op_in_s), .a_in(a_in_s),
        .b_in(b_in_s), .alu_op(alu_op_s[0]), .alu_a(alu_a_s[0]), .alu_b(alu_b_s[0]),
        .alu_result(alu_result_s[0]), .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s),
        .rsp_id(rsp_id_s[0]), .rsp_data(rsp_data_s[0]), .busy(busy_s[0])
    );

    alu_arbiter #(.ALU_LAT(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .req(req_s), .op_in(op_in_s), .a_in(a_in_s),
        .b_in(b_in_s), .alu_op(alu_op_s[1]), .alu_a(alu_a_s[1]), .alu_b(alu_b_s[1]),
        .alu_result(alu_result_s[1]), .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s),
        .rsp_id(rsp_id_s[1]), .rsp_data(rsp_data_s[1]), .busy(busy_s[1])
    );

    assign alu_result_s[0] = alu_fn(alu_op_s[0], alu_a_s[0], alu_b_s[0]) ^ noise_s;
    assign alu_result_s[1] = alu_fn(alu_op_s[1], alu_a_s[1], alu_b_s[1]) ^ noise_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]   = 1'b0;
            m_valid[d]  = 1'b0;
            m_edges[d]  = 0;
            m_id[d]     = 0;
            m_last[d]   = 3;
            m_id_out[d] = 0;
            e_op[d]     = 3'd0;
            e_a[d]      = 32'd0;
            e_b[d]      = 32'd0;
            m_data[d]   = 32'd0;
        end
    endtask

    // One rising edge of the transaction model: grant, count ISSUE edges, capture, accept.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int w;
            if (m_valid[d]) begin
                if (rsp_ready_s) begin
                    m_valid[d] = 1'b0;
                    m_busy[d]  = 1'b0;
                end
            end else if (m_busy[d]) begin
                m_edges[d]++;
                if (m_edges[d] == lat_of(d)) begin
                    m_valid[d]  = 1'b1;
                    m_data[d]   = alu_fn(e_op[d], e_a[d], e_b[d]) ^ noise_s;
                    m_id_out[d] = m_id[d];
                end
            end else if (req_s != 4'd0) begin
                w          = model_pick(req_s, m_last[d]);
                e_op[d]    = op_in_s[3*w +: 3];
                e_a[d]     = a_in_s[32*w +: 32];
                e_b[d]     = b_in_s[32*w +: 32];
                m_id[d]    = w;
                m_last[d]  = w;
                m_busy[d]  = 1'b1;
                m_edges[d] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            int l;
            l = lat_of(d);
            check_val($sformatf("busy_L%0d", l), 32'(busy_s[d]), 32'(m_busy[d]));
            check_val($sformatf("rsp_valid_L%0d", l), 32'(rsp_valid_s[d]), 32'(m_valid[d]));
            check_val($sformatf("alu_op_L%0d", l), 32'(alu_op_s[d]), 32'(e_op[d]));
            check_val($sformatf("alu_a_L%0d", l), alu_a_s[d], e_a[d]);
            check_val($sformatf("alu_b_L%0d", l), alu_b_s[d], e_b[d]);
            if (m_valid[d]) begin
                check_val($sformatf("rsp_id_L%0d", l), 32'(rsp_id_s[d]), 32'(m_id_out[d]));
                check_val($sformatf("rsp_data_L%0d", l), rsp_data_s[d], m_data[d]);
                obs_id[d]   = int'(rsp_id_s[d]);
                obs_data[d] = int'(rsp_data_s[d]);
            end
            if (log_en && rsp_valid_s[d] && rsp_ready_s) begin
                if (d == 0) gnt_log0.push_back(int'(rsp_id_s[d]));
                else        gnt_log1.push_back(int'(rsp_id_s[d]));
            end
        end
    endtask

    task automatic check_reset_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("%s_busy_L%0d", tag, lat_of(d)), 32'(busy_s[d]), 32'd0);
            check_val($sformatf("%s_valid_L%0d", tag, lat_of(d)), 32'(rsp_valid_s[d]), 32'd0);
            check_val($sformatf("%s_id_L%0d", tag, lat_of(d)), 32'(rsp_id_s[d]), 32'd0);
            check_val($sformatf("%s_data_L%0d", tag, lat_of(d)), rsp_data_s[d], 32'd0);
            check_val($sformatf("%s_op_L%0d", tag, lat_of(d)), 32'(alu_op_s[d]), 32'd0);
            check_val($sformatf("%s_a_L%0d", tag, lat_of(d)), alu_a_s[d], 32'd0);
            check_val($sformatf("%s_b_L%0d", tag, lat_of(d)), alu_b_s[d], 32'd0);
        end
    endtask

    // Advance one cycle: model follows the rising edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_outputs();
        if (noise_en) noise_s = $urandom();
    endtask

    task automatic fill_ops();
        op_in_s = 12'($urandom());
        a_in_s  = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_in_s  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Let any in-flight transaction finish with no new requests, bounded.
    task automatic drain(input string tag);
        req_s       = 4'd0;
        rsp_ready_s = 1'b1;
        for (int i = 0; i < 40 && (busy_s[0] || busy_s[1] || m_busy[0] || m_busy[1]); i++) step();
        check_val({tag, "_drain_L1"}, 32'(busy_s[0]), 32'd0);
        check_val({tag, "_drain_L3"}, 32'(busy_s[1]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req_s = 4'd0;
        op_in_s = 12'd0;
        a_in_s = 128'd0;
        b_in_s = 128'd0;
        rsp_ready_s = 1'b0;
        noise_s = 32'd0;
        noise_en = 1'b0;
        log_en = 1'b0;
`ifdef ALU_ARB_RR_EN
        exp_gnt = '{0, 1, 2, 3, 0};
`else
        exp_gnt = '{0, 0, 0, 0, 0};
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_zero("reset");
        rst_n = 1'b1;

        // All four requesting continuously: grant order follows the arbitration rule.
        fill_ops();
        req_s       = 4'b1111;
        rsp_ready_s = 1'b1;
        log_en      = 1'b1;
        for (int i = 0; i < 80 && (gnt_log0.size() < 5 || gnt_log1.size() < 5); i++) step();
        log_en = 1'b0;
        drain("allreq");
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("grant%0d_L1", i), (i < gnt_log0.size()) ? gnt_log0[i] : 99, exp_gnt[i]);
            check_val($sformatf("grant%0d_L3", i), (i < gnt_log1.size()) ? gnt_log1[i] : 99, exp_gnt[i]);
        end

        // Single request from requester 0: op 010 (add), 5 + 3 = 8.
        op_in_s = 12'd0;
        a_in_s  = 128'd0;
        b_in_s  = 128'd0;
        op_in_s[2:0] = 3'b010;
        a_in_s[31:0] = 32'd5;
        b_in_s[31:0] = 32'd3;
        obs_id = '{-1, -1};
        req_s = 4'b0001;
        step();
        check_val("basic_alu_op", 32'(alu_op_s[0]), 32'd2);
        req_s = 4'b0000;
        step();
        check_val("basic_valid_t2", 32'(rsp_valid_s[0]), 32'd1);
        drain("basic");
        check_val("basic_id", obs_id[0], 0);
        check_val("basic_data_L1", obs_data[0], 8);
        check_val("basic_data_L3", obs_data[1], 8);

        // Back-pressure: response held while rsp_ready stays low, no new issue.
        fill_ops();
        req_s       = 4'b1111;
        rsp_ready_s = 1'b0;
        repeat (10) step();
        rsp_ready_s = 1'b1;
        step();
        drain("stall");

        // Reset in the middle of ISSUE drops the transaction.
        fill_ops();
        req_s = 4'b0001;
        step();
        req_s = 4'b0000;
        rst_n = 1'b0;
        #1;
        check_reset_zero("midreset");
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        fill_ops();
        obs_id = '{-1, -1};
        req_s = 4'b0100;
        step();
        drain("postreset");
        check_val("postreset_id_L1", obs_id[0], 2);
        check_val("postreset_id_L3", obs_id[1], 2);

        // Request dropped during ISSUE while alu_result keeps changing every cycle.
        noise_en = 1'b1;
        fill_ops();
        obs_id = '{-1, -1};
        req_s = 4'b1000;
        step();
        req_s = 4'b0000;
        drain("reqdrop");
        check_val("reqdrop_id_L1", obs_id[0], 3);
        check_val("reqdrop_id_L3", obs_id[1], 3);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            req_s       = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'd0;
            rsp_ready_s = ($urandom_range(0, 3) != 0);
            fill_ops();
            step();
        end
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
